// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - data-memory responder: word RAM plus console/tohost/cycle/fault MMIO window
module dmem_responder #(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000,
  parameter int          CONS_DEPTH  = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wen,
  input  logic        ren,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        err,
  output logic [7:0]  cons_data,
  output logic        cons_valid,
  input  logic        cons_ready,
  output logic [31:0] tohost,
  output logic        halt
);
  localparam int          AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int          PW        = $clog2(CONS_DEPTH);
  localparam logic [32:0] RAM_LIMIT = 33'(DEPTH_WORDS) * 33'd4;
  localparam logic [32:0] MMIO_LO   = {1'b0, MMIO_BASE};
  localparam logic [32:0] MMIO_HI   = MMIO_LO + 33'd16;
  localparam logic [PW:0] FIFO_FULL = (PW + 1)'(CONS_DEPTH);

  logic [31:0]   mem      [DEPTH_WORDS];
  logic [7:0]    cons_mem [CONS_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count;
  logic          overflow;
  logic [31:0]   cycle, faultcnt;

  logic [AW-1:0] word_idx;
  logic [1:0]    reg_sel;
  logic          is_ram, is_mmio, fault, store_ok;
  logic          ram_we, tohost_we, fcnt_clr;
  logic          fifo_empty, fifo_full, pop, push_req, push;
  logic [31:0]   mmio_rdata;

  // MMIO_BASE is 16-byte aligned, so the register select is just addr[3:2]
  assign word_idx = addr[AW+1:2];
  assign reg_sel  = addr[3:2];
  assign is_ram   = {1'b0, addr} < RAM_LIMIT;
  assign is_mmio  = ({1'b0, addr} >= MMIO_LO) && ({1'b0, addr} < MMIO_HI);
  assign fault    = (wen | ren) & ((addr[1:0] != 2'b00) | ~(is_ram | is_mmio));

  // Console pushes stay live after halt so final prints still drain
  assign store_ok  = wen & ~fault & ~rst;
  assign ram_we    = store_ok & is_ram & ~halt;
  assign push_req  = store_ok & is_mmio & (reg_sel == 2'd0);
  assign tohost_we = store_ok & is_mmio & (reg_sel == 2'd1) & ~halt;
  assign fcnt_clr  = store_ok & is_mmio & (reg_sel == 2'd3) & ~halt;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == FIFO_FULL);
  assign cons_valid = ~fifo_empty;
  assign cons_data  = fifo_empty ? 8'h00 : cons_mem[rd_ptr];
  assign pop        = cons_valid & cons_ready;
  assign push       = push_req & (~fifo_full | pop);

  always_comb begin
    mmio_rdata = '0;
    case (reg_sel)
      2'd0:    mmio_rdata = {29'b0, overflow, fifo_empty, fifo_full};
      2'd1:    mmio_rdata = tohost;
      2'd2:    mmio_rdata = cycle;
      default: mmio_rdata = faultcnt;
    endcase
  end

  always_ff @(posedge clk) begin
    if (ram_we) mem[word_idx] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (push) cons_mem[wr_ptr] <= wdata[7:0];
  end

  // Read-before-write: a same-cycle store to the read word returns the old data
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
      err   <= 1'b0;
    end else begin
      err <= fault;
      if (ren) begin
        if (fault)       rdata <= '0;
        else if (is_ram) rdata <= mem[word_idx];
        else             rdata <= mmio_rdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle    <= '0;
      faultcnt <= '0;
      tohost   <= '0;
      halt     <= 1'b0;
      overflow <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      cycle <= cycle + 32'd1;
      if (fault) begin
        if (faultcnt != 32'hFFFF_FFFF) faultcnt <= faultcnt + 32'd1;
      end else if (fcnt_clr) begin
        faultcnt <= '0;
      end
      if (tohost_we) begin
        tohost <= wdata;
        if (wdata[0]) halt <= 1'b1;
      end
      if (push_req && !push) overflow <= 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule
